// File: rtl/ga_defs_pkg.sv
// Shared GA definitions: controller phase codes, fitness width helper,
// selection FSM state encodings and the LFSR feedback mask.
package ga_defs_pkg;

  localparam logic [2:0] FITNESS_CONTROLLER   = 3'b001;
  localparam logic [2:0] SELECTION_CONTROLLER = 3'b010;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_DRAW_A  = 3'd1;
  localparam logic [2:0] ST_DRAW_B  = 3'd2;
  localparam logic [2:0] ST_COMPARE = 3'd3;
  localparam logic [2:0] ST_EMIT    = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;
  localparam logic [2:0] ST_ELITE   = 3'd6;

  localparam logic [15:0] LFSR_MASK = 16'hB400;

  typedef logic [7:0] indiv_t;

  // Fitness counts mismatching truth-table rows, plus headroom for the gene outputs.
  function automatic int fitWidth(input int primaryInputCount);
    return primaryInputCount + 2;
  endfunction

endpackage

// File: rtl/ga_lfsr.sv
// 16-bit right-shifting Galois LFSR with enable; exposes the low OUT_W bits.
// Shared by selection now and crossover/mutation later.
module ga_lfsr
  import ga_defs_pkg::*;
#(
  parameter logic [15:0] seed  = 16'hACE1,
  parameter int          OUT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic [OUT_W-1:0] value
);

  logic [15:0] lfsrReg;
  logic [15:0] lfsrNext;

  always_comb begin
    lfsrNext = lfsrReg >> 1;
    if (lfsrReg[0]) lfsrNext = (lfsrReg >> 1) ^ LFSR_MASK;
  end

  always_ff @(posedge clk) begin
    if (reset)       lfsrReg <= seed;
    else if (enable) lfsrReg <= lfsrNext;
  end

  assign value = lfsrReg[OUT_W-1:0];

endmodule

// File: rtl/tournament_selection.sv
// Fitness capture, best tracking and 2-way tournament parent selection.
// Optional ELITISM_EN: the first parent of each run is the current best individual.
module tournament_selection
  import ga_defs_pkg::*;
#(
  parameter int          population           = 24,
  parameter int          primaryInputCount    = 8,
  parameter int          geneResultBit        = 2,
  parameter int          parentCount          = 24,
  parameter logic [2:0]  fitness_controller   = FITNESS_CONTROLLER,
  parameter logic [2:0]  selection_controller = SELECTION_CONTROLLER,
  parameter logic [15:0] lfsrSeed             = 16'hACE1,
  localparam int         FIT_W                = fitWidth(primaryInputCount)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       state_controller,
  input  logic [FIT_W-1:0] fitness,
  input  logic [7:0]       fitCounter,
  output logic [7:0]       sel_idx,
  output logic             sel_valid,
  input  logic             sel_ready,
  output logic [7:0]       best_idx,
  output logic [FIT_W-1:0] best_fitness,
  output logic             gene_found,
  output logic             selection_done,
  output logic [2:0]       state_selectionFSM
);

  localparam int               IDX_W       = (population > 1) ? $clog2(population) : 1;
  localparam indiv_t           POP8        = 8'(population);
  localparam indiv_t           PARENT_LAST = 8'(parentCount - 1);
  localparam logic [FIT_W-1:0] GENE_FIT    = FIT_W'(geneResultBit);

  logic [FIT_W-1:0] fitMem [population];
  logic [7:0]       fitCounterQ;
  logic [7:0]       capturedCount;
  logic [7:0]       emitCount;
  logic [2:0]       stateReg;
  indiv_t           idxA;
  indiv_t           idxB;
  indiv_t           selIdxReg;
  logic             selValidReg;
  logic             doneReg;
  indiv_t           bestIdxReg;
  logic [FIT_W-1:0] bestFitReg;
  logic             geneFoundReg;

  logic             captureEn;
  logic             newGen;
  logic [7:0]       captureIdx;
  logic             selPhase;
  logic             doneExit;
  logic             lfsrEn;
  indiv_t           cand;
  indiv_t           winner;
  logic [FIT_W-1:0] fitA;
  logic [FIT_W-1:0] fitB;

  assign selPhase   = (state_controller == selection_controller);
  assign captureEn  = (state_controller == fitness_controller) &&
                      (fitCounter != fitCounterQ) && (fitCounter != 8'd0);
  assign newGen     = (fitCounter == 8'd0) && (fitCounterQ != 8'd0);
  assign captureIdx = fitCounter - 8'd1;
  assign doneExit   = (stateReg == ST_DONE) && !selPhase;
  assign lfsrEn     = (stateReg == ST_DRAW_A) || (stateReg == ST_DRAW_B);

  ga_lfsr #(.seed(lfsrSeed), .OUT_W(8)) u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .enable (lfsrEn),
    .value  (cand)
  );

  // One register slot per individual; read asynchronously by the tournament compare.
  for (genvar gi = 0; gi < population; gi++) begin : g_slot
    logic [FIT_W-1:0] slotReg;
    always_ff @(posedge clk) begin
      if (captureEn && captureIdx == 8'(gi)) slotReg <= fitness;
    end
    assign fitMem[gi] = slotReg;
  end

  assign fitA = fitMem[idxA[IDX_W-1:0]];
  assign fitB = fitMem[idxB[IDX_W-1:0]];
  // Ties go to the lower index so results do not depend on draw order.
  assign winner = ((fitB < fitA) || ((fitB == fitA) && (idxB < idxA))) ? idxB : idxA;

  always_ff @(posedge clk) begin
    if (reset) begin
      fitCounterQ   <= 8'd0;
      capturedCount <= 8'd0;
      bestIdxReg    <= 8'd0;
      bestFitReg    <= '1;
      geneFoundReg  <= 1'b0;
    end else begin
      fitCounterQ <= fitCounter;
      if (newGen) begin
        capturedCount <= 8'd0;
        bestIdxReg    <= 8'd0;
        bestFitReg    <= '1;
        geneFoundReg  <= 1'b0;
      end else begin
        if (doneExit) begin
          capturedCount <= 8'd0;
          geneFoundReg  <= 1'b0;
        end
        if (captureEn) begin
          capturedCount <= (doneExit ? 8'd0 : capturedCount) + 8'd1;
          if (fitness < bestFitReg) begin
            bestFitReg <= fitness;
            bestIdxReg <= captureIdx;
          end
          if (fitness == GENE_FIT) geneFoundReg <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg    <= ST_IDLE;
      idxA        <= 8'd0;
      idxB        <= 8'd0;
      selIdxReg   <= 8'd0;
      selValidReg <= 1'b0;
      emitCount   <= 8'd0;
      doneReg     <= 1'b0;
    end else if (!selPhase && stateReg != ST_IDLE && stateReg != ST_DONE) begin
      // Phase withdrawn mid-run: abandon it, keeping the captured fitness data.
      stateReg    <= ST_IDLE;
      selValidReg <= 1'b0;
      emitCount   <= 8'd0;
    end else begin
      case (stateReg)
        ST_IDLE: begin
          if (selPhase && capturedCount == POP8) begin
`ifdef ELITISM_EN
            selIdxReg   <= bestIdxReg;
            selValidReg <= 1'b1;
            stateReg    <= ST_ELITE;
`else
            stateReg    <= ST_DRAW_A;
`endif
          end
        end
        ST_DRAW_A: begin
          if (cand < POP8) begin
            idxA     <= cand;
            stateReg <= ST_DRAW_B;
          end
        end
        ST_DRAW_B: begin
          if (cand < POP8) begin
            idxB     <= cand;
            stateReg <= ST_COMPARE;
          end
        end
        ST_COMPARE: begin
          selIdxReg   <= winner;
          selValidReg <= 1'b1;
          stateReg    <= ST_EMIT;
        end
`ifdef ELITISM_EN
        ST_ELITE,
`endif
        ST_EMIT: begin
          if (selValidReg && sel_ready) begin
            selValidReg <= 1'b0;
            emitCount   <= emitCount + 8'd1;
            if (emitCount == PARENT_LAST) begin
              stateReg <= ST_DONE;
              doneReg  <= 1'b1;
            end else begin
              stateReg <= ST_DRAW_A;
            end
          end
        end
        ST_DONE: begin
          if (!selPhase) begin
            stateReg  <= ST_IDLE;
            emitCount <= 8'd0;
            doneReg   <= 1'b0;
          end
        end
        default: stateReg <= ST_IDLE;
      endcase
    end
  end

  assign sel_idx            = selIdxReg;
  assign sel_valid          = selValidReg;
  assign best_idx           = bestIdxReg;
  assign best_fitness       = bestFitReg;
  assign gene_found         = geneFoundReg;
  assign selection_done     = doneReg;
  assign state_selectionFSM = stateReg;

endmodule

// File: tb/tb_tournament_selection.sv
// Scoreboard bench for tournament_selection: reference LFSR model predicts every
// parent index; captures, best tracking, abort and reset are checked directly.
`timescale 1ns/1ps
module tb_tournament_selection;

  localparam int         POP     = 24;
  localparam int         FW      = 10;
  localparam int         PARENTS = 24;
  localparam logic [2:0] PH_OFF  = 3'b000;
  localparam logic [2:0] PH_FIT  = 3'b001;
  localparam logic [2:0] PH_SEL  = 3'b010;

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    state_controller;
  logic [FW-1:0] fitness;
  logic [7:0]    fitCounter;
  logic [7:0]    sel_idx;
  logic          sel_valid;
  logic          sel_ready;
  logic [7:0]    best_idx;
  logic [FW-1:0] best_fitness;
  logic          gene_found;
  logic          selection_done;
  logic [2:0]    state_selectionFSM;

  tournament_selection #(
    .population(POP), .primaryInputCount(8), .geneResultBit(2), .parentCount(PARENTS),
    .fitness_controller(PH_FIT), .selection_controller(PH_SEL), .lfsrSeed(16'hACE1)
  ) dut (
    .clk(clk), .reset(reset), .state_controller(state_controller), .fitness(fitness),
    .fitCounter(fitCounter), .sel_idx(sel_idx), .sel_valid(sel_valid), .sel_ready(sel_ready),
    .best_idx(best_idx), .best_fitness(best_fitness), .gene_found(gene_found),
    .selection_done(selection_done), .state_selectionFSM(state_selectionFSM)
  );

  always #5 clk = ~clk;

  int          assertCount = 0;
  int          failCount = 0;
  int          fitModel [POP];
  int          bestModelIdx = 0;
  logic [15:0] modelLfsr = 16'hACE1;
  int          expQ [$];

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // Consume reference LFSR values until one names a valid individual.
  task automatic drawIdx(output int idx);
    int c;
    do begin
      c = int'(modelLfsr[7:0]);
      if (modelLfsr[0]) modelLfsr = (modelLfsr >> 1) ^ 16'hB400;
      else              modelLfsr = modelLfsr >> 1;
    end while (c >= POP);
    idx = c;
  endtask

  task automatic pushRun(input int n);
    int a, b, first;
    first = 0;
`ifdef ELITISM_EN
    expQ.push_back(bestModelIdx);
    first = 1;
`endif
    for (int k = first; k < n; k++) begin
      drawIdx(a);
      drawIdx(b);
      if (fitModel[a] < fitModel[b])      expQ.push_back(a);
      else if (fitModel[b] < fitModel[a]) expQ.push_back(b);
      else                                expQ.push_back((a < b) ? a : b);
    end
  endtask

  task automatic feedGen(input int geneAt, input string tag);
    int bestF, bestI;
    bit gene;
    @(negedge clk);
    state_controller = PH_FIT;
    fitCounter = 8'd0;
    fitness = '0;
    @(negedge clk);
    checkEq({tag, "_clr_bestfit"}, 32'(best_fitness), 1023);
    checkEq({tag, "_clr_gene"}, 32'(gene_found), 0);
    bestF = 1024; bestI = 0; gene = 1'b0;
    for (int k = 1; k <= POP; k++) begin
      fitness = FW'(fitModel[k-1]);
      fitCounter = 8'(k);
      if (fitModel[k-1] < bestF) begin bestF = fitModel[k-1]; bestI = k - 1; end
      if (fitModel[k-1] == 2) gene = 1'b1;
      @(negedge clk);
      if (k == geneAt - 1) checkEq({tag, "_gene_before"}, 32'(gene_found), 0);
      if (k == geneAt)     checkEq({tag, "_gene_at"}, 32'(gene_found), 1);
    end
    bestModelIdx = bestI;
    checkEq({tag, "_best_idx"}, 32'(best_idx), bestI);
    checkEq({tag, "_best_fit"}, 32'(best_fitness), bestF);
    checkEq({tag, "_gene_end"}, 32'(gene_found), 32'(gene));
  endtask

  task automatic takeEmission(input int holdCycles, input bit accept, input string tag);
    int n, expIdx;
    n = 0;
    while (sel_valid !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (sel_valid !== 1'b1) begin
      checkEq({tag, "_valid_timeout"}, 32'(sel_valid), 1);
      return;
    end
    if (expQ.size() == 0) begin
      checkEq({tag, "_unexpected_emit"}, 32'(sel_valid), 0);
      return;
    end
    expIdx = expQ.pop_front();
    checkEq({tag, "_idx"}, 32'(sel_idx), expIdx);
    for (int h = 0; h < holdCycles; h++) begin
      @(negedge clk);
      checkEq({tag, "_hold_valid"}, 32'(sel_valid), 1);
      checkEq({tag, "_hold_idx"}, 32'(sel_idx), expIdx);
    end
    if (accept) begin
      sel_ready = 1'b1;
      @(negedge clk);
      sel_ready = 1'b0;
      checkEq({tag, "_valid_drop"}, 32'(sel_valid), 0);
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    state_controller = PH_OFF;
    fitness = '0;
    fitCounter = 8'd0;
    sel_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkEq("rst_sel_valid", 32'(sel_valid), 0);
    checkEq("rst_sel_idx", 32'(sel_idx), 0);
    checkEq("rst_best_idx", 32'(best_idx), 0);
    checkEq("rst_best_fit", 32'(best_fitness), 1023);
    checkEq("rst_gene", 32'(gene_found), 0);
    checkEq("rst_done", 32'(selection_done), 0);
    checkEq("rst_state", 32'(state_selectionFSM), 0);
    reset = 1'b0;

    // Generation 1: fitness 24..1 (individual 22 hits the perfect value 2).
    for (int i = 0; i < POP; i++) fitModel[i] = POP - i;
    feedGen(23, "gen1");

    // Generation 2: tie at 7 on individuals 3 and 9, many ties elsewhere.
    for (int i = 0; i < POP; i++) fitModel[i] = (i == 3 || i == 9) ? 7 : 8 + (i % 4);
    feedGen(0, "gen2");

    pushRun(PARENTS);
    @(negedge clk);
    state_controller = PH_SEL;
    takeEmission(10, 1'b1, "runA_0");
    for (int k = 1; k < PARENTS - 1; k++) takeEmission(0, 1'b1, $sformatf("runA_%0d", k));
    checkEq("runA_done_early", 32'(selection_done), 0);
    takeEmission(0, 1'b1, "runA_last");
    checkEq("runA_done", 32'(selection_done), 1);
    checkEq("runA_state_done", 32'(state_selectionFSM), 5);
    state_controller = PH_OFF;
    @(negedge clk);
    checkEq("runA_idle_done", 32'(selection_done), 0);
    checkEq("runA_idle_state", 32'(state_selectionFSM), 0);

    // Generation 3: perfect gene at individual 5, best (1) at individual 17.
    for (int i = 0; i < POP; i++) fitModel[i] = 3 + (i * 5) % 11;
    fitModel[5] = 2;
    fitModel[17] = 1;
    feedGen(6, "gen3");

    // Abort on the third emission, then a full run must restart from zero.
    pushRun(3);
    @(negedge clk);
    state_controller = PH_SEL;
`ifdef ELITISM_EN
    checkEq("elite_queue_head", 32'(expQ[0]), 17);
`endif
    takeEmission(0, 1'b1, "runB_0");
    takeEmission(0, 1'b1, "runB_1");
    takeEmission(0, 1'b0, "runB_abort");
    state_controller = PH_OFF;
    @(negedge clk);
    checkEq("abort_valid", 32'(sel_valid), 0);
    checkEq("abort_state", 32'(state_selectionFSM), 0);

    pushRun(PARENTS);
    state_controller = PH_SEL;
    for (int k = 0; k < PARENTS - 1; k++) takeEmission(0, 1'b1, $sformatf("runC_%0d", k));
    checkEq("runC_done_early", 32'(selection_done), 0);
    takeEmission(0, 1'b1, "runC_last");
    checkEq("runC_done", 32'(selection_done), 1);
    state_controller = PH_OFF;
    @(negedge clk);
    checkEq("runC_idle_state", 32'(state_selectionFSM), 0);

    // Generation 4: reset while a parent index is being offered.
    for (int i = 0; i < POP; i++) fitModel[i] = 3 + (i * 7) % 13;
    feedGen(0, "gen4");
    pushRun(1);
    @(negedge clk);
    state_controller = PH_SEL;
    takeEmission(0, 1'b0, "pre_reset");
    reset = 1'b1;
    state_controller = PH_OFF;
    @(negedge clk);
    checkEq("midrst_valid", 32'(sel_valid), 0);
    checkEq("midrst_state", 32'(state_selectionFSM), 0);
    checkEq("midrst_best_fit", 32'(best_fitness), 1023);
    checkEq("midrst_best_idx", 32'(best_idx), 0);
    checkEq("midrst_done", 32'(selection_done), 0);
    reset = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
